// File: rtl/alu_seq_if.sv
// Handshake bundle between the operand producer and alu_seq: a request channel
// (operands plus opcode) and a response channel (result plus flags).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_input_a;
    logic [WIDTH-1:0] alu_input_b;
    logic [3:0]       alu_opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             zero;
    logic             illegal_op;

    modport master (
        output in_valid, alu_input_a, alu_input_b, alu_opcode, out_ready,
        input  in_ready, out_valid, alu_out, zero, illegal_op
    );

    modport slave (
        input  in_valid, alu_input_a, alu_input_b, alu_opcode, out_ready,
        output in_ready, out_valid, alu_out, zero, illegal_op
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags and shift-add multiply.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational multiplier instead.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLL   = 4'd4;
    localparam logic [3:0] OP_SRL   = 4'd5;
    localparam logic [3:0] OP_SNE   = 4'd6;
    localparam logic [3:0] OP_OVF   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MULLO = 4'd11;
    localparam logic [3:0] OP_MULHI = 4'd12;

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

`ifdef ALU_SEQ_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`endif

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a, b, sum, diff, op_result;
    logic             op_illegal;
    logic             is_mul;
    logic             accept;
    logic             in_ready_c;
    logic             out_valid_c;

    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             illegal_reg;

    assign a    = bus.alu_input_a;
    assign b    = bus.alu_input_b;
    assign sum  = a + b;
    assign diff = a - b;

`ifdef ALU_SEQ_FAST_MUL_EN
    logic [2*WIDTH-1:0] product;
    assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign is_mul  = 1'b0;
`else
    logic [WIDTH-1:0]   mcand_reg;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH:0]     partial;
    logic [CNT_W-1:0]   cnt_reg;
    logic               hi_sel_reg;
    logic [WIDTH-1:0]   mul_result;

    assign is_mul = (bus.alu_opcode == OP_MULLO) || (bus.alu_opcode == OP_MULHI);

    // Upper half accumulates the multiplicand when the multiplier LSB (acc[0]) is
    // set; the whole accumulator then shifts right, retiring one multiplier bit.
    assign partial    = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
    assign acc_next   = {partial, acc_reg[WIDTH-1:1]};
    assign mul_result = hi_sel_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
`endif

    always_comb begin
        op_result  = '0;
        op_illegal = 1'b0;
        case (bus.alu_opcode)
            OP_AND: op_result = a & b;
            OP_ADD: op_result = sum;
            OP_XOR: op_result = a ^ b;
            OP_SLT: op_result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL: op_result = (b >= SHIFT_LIM) ? '0 : (a << b);
            OP_SRL: op_result = (b >= SHIFT_LIM) ? '0 : (a >> b);
            OP_SNE: op_result = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_OVF: op_result = {{(WIDTH-1){1'b0}},
                                 ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]))};
            OP_SUB: op_result = diff;
            OP_OR:  op_result = a | b;
            OP_SRA: op_result = (b >= SHIFT_LIM) ? {WIDTH{a[WIDTH-1]}}
                                                 : WIDTH'($signed(a) >>> b);
`ifdef ALU_SEQ_FAST_MUL_EN
            OP_MULLO: op_result = product[WIDTH-1:0];
            OP_MULHI: op_result = product[2*WIDTH-1:WIDTH];
`else
            OP_MULLO, OP_MULHI: op_result = '0;
`endif
            default: op_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_reg)
            IDLE: in_ready_c = 1'b1;
`ifndef ALU_SEQ_FAST_MUL_EN
            BUSY: if (cnt_reg == CNT_LAST) state_next = DONE;
`endif
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A release in DONE can coincide with a new accept (back-to-back).
        if (bus.in_valid && in_ready_c) begin
`ifdef ALU_SEQ_FAST_MUL_EN
            state_next = DONE;
`else
            state_next = is_mul ? BUSY : DONE;
`endif
        end
    end

    assign accept = bus.in_valid && in_ready_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg  <= '0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
`ifndef ALU_SEQ_FAST_MUL_EN
            mcand_reg   <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            hi_sel_reg  <= 1'b0;
`endif
        end else begin
            if (accept && !is_mul) begin
                result_reg  <= op_result;
                zero_reg    <= (op_result == '0);
                illegal_reg <= op_illegal;
            end
`ifndef ALU_SEQ_FAST_MUL_EN
            if (accept && is_mul) begin
                mcand_reg  <= a;
                acc_reg    <= {{WIDTH{1'b0}}, b};
                cnt_reg    <= '0;
                hi_sel_reg <= (bus.alu_opcode == OP_MULHI);
            end else if (state_reg == BUSY) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_LAST) begin
                    result_reg  <= mul_result;
                    zero_reg    <= (mul_result == '0);
                    illegal_reg <= 1'b0;
                end
            end
`endif
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.alu_out    = result_reg;
    assign bus.zero       = zero_reg;
    assign bus.illegal_op = illegal_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8: single-cycle ops, illegal
// opcodes, multiply latency, output stall, streaming and reset during a multiply.
module tb_alu_seq;
    localparam int WIDTH = 8;
`ifdef ALU_SEQ_FAST_MUL_EN
    localparam int MUL_WAIT = 0;
`else
    localparam int MUL_WAIT = WIDTH;
`endif

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {opcode, a, b, expected alu_out}, hand-computed for WIDTH=8
    localparam int NV = 20;
    localparam logic [27:0] VEC [NV] = '{
        {4'd0,  8'hF0, 8'h3C, 8'h30},
        {4'd1,  8'hFF, 8'h01, 8'h00},
        {4'd1,  8'h7F, 8'h7F, 8'hFE},
        {4'd2,  8'hAA, 8'hFF, 8'h55},
        {4'd3,  8'h03, 8'h05, 8'h01},
        {4'd3,  8'h05, 8'h03, 8'h00},
        {4'd4,  8'h01, 8'h08, 8'h00},
        {4'd4,  8'h81, 8'h01, 8'h02},
        {4'd5,  8'h80, 8'h03, 8'h10},
        {4'd5,  8'hFF, 8'hC8, 8'h00},
        {4'd6,  8'h05, 8'h05, 8'h00},
        {4'd6,  8'h05, 8'h06, 8'h01},
        {4'd7,  8'h7F, 8'h01, 8'h01},
        {4'd7,  8'h80, 8'h80, 8'h01},
        {4'd7,  8'h7F, 8'h80, 8'h00},
        {4'd8,  8'h05, 8'h07, 8'hFE},
        {4'd9,  8'h0F, 8'h30, 8'h3F},
        {4'd10, 8'h80, 8'h09, 8'hFF},
        {4'd10, 8'h80, 8'h01, 8'hC0},
        {4'd10, 8'h40, 8'h02, 8'h10}
    };

    localparam int NM = 5;
    localparam logic [27:0] MVEC [NM] = '{
        {4'd11, 8'hFF, 8'hFF, 8'h01},
        {4'd12, 8'hFF, 8'hFF, 8'hFE},
        {4'd11, 8'h0D, 8'h0B, 8'h8F},
        {4'd12, 8'h10, 8'h20, 8'h02},
        {4'd12, 8'h01, 8'h01, 8'h00}
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid    = 1'b1;
        bus.alu_opcode  = op;
        bus.alu_input_a = a;
        bus.alu_input_b = b;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(4'd0, 8'h00, 8'h00);
        bus.in_valid  = 1'b0;
        tick();
        tick();
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        if (bus.alu_out !== 8'h00) begin errors++; $display("FAIL reset_alu_out got=%h want=00", bus.alu_out); end
        if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got=%b want=0", bus.zero); end
        if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", bus.illegal_op); end
        $display("reset: out_valid=%b in_ready=%b alu_out=%h", bus.out_valid, bus.in_ready, bus.alu_out);
        reset = 1'b0;
    endtask

    task automatic test_single_ops;
        logic [27:0] v;
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            v = VEC[i];
            drive(v[27:24], v[23:16], v[15:8]);
            tick();
            bus.in_valid = 1'b0;
            checks += 4;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_out_valid vec=%0d got=%b want=1", v[27:24], i, bus.out_valid); end
            if (bus.alu_out !== v[7:0]) begin errors++; $display("FAIL op%0d_alu_out vec=%0d got=%h want=%h", v[27:24], i, bus.alu_out, v[7:0]); end
            if (bus.zero !== (v[7:0] == 8'h00)) begin errors++; $display("FAIL op%0d_zero vec=%0d got=%b want=%b", v[27:24], i, bus.zero, (v[7:0] == 8'h00)); end
            if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL op%0d_illegal vec=%0d got=%b want=0", v[27:24], i, bus.illegal_op); end
            $display("op=%0d a=%h b=%h -> alu_out=%h zero=%b", v[27:24], v[23:16], v[15:8], bus.alu_out, bus.zero);
        end
    endtask

    task automatic test_illegal;
        for (int op = 13; op < 16; op++) begin
            drive(4'(op), 8'hFF, 8'hFF);
            tick();
            bus.in_valid = 1'b0;
            checks += 4;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL illegal%0d_out_valid got=%b want=1", op, bus.out_valid); end
            if (bus.alu_out !== 8'h00) begin errors++; $display("FAIL illegal%0d_alu_out got=%h want=00", op, bus.alu_out); end
            if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL illegal%0d_flag got=%b want=1", op, bus.illegal_op); end
            if (bus.zero !== 1'b1) begin errors++; $display("FAIL illegal%0d_zero got=%b want=1", op, bus.zero); end
            $display("op=%0d -> alu_out=%h illegal_op=%b", op, bus.alu_out, bus.illegal_op);
        end
    endtask

    task automatic test_multiply;
        logic [27:0] v;
        int k;
        for (int i = 0; i < NM; i++) begin
            v = MVEC[i];
            drive(v[27:24], v[23:16], v[15:8]);
            tick();
            bus.in_valid = 1'b0;
            k = 0;
            while (!bus.out_valid && k < 20) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_in_ready cycle=%0d got=%b want=0", k, bus.in_ready); end
                tick();
                k++;
            end
            checks += 4;
            if (k != MUL_WAIT) begin errors++; $display("FAIL mul_latency got=%0d want=%0d", k + 1, MUL_WAIT + 1); end
            if (bus.alu_out !== v[7:0]) begin errors++; $display("FAIL mul_op%0d_alu_out got=%h want=%h", v[27:24], bus.alu_out, v[7:0]); end
            if (bus.zero !== (v[7:0] == 8'h00)) begin errors++; $display("FAIL mul_op%0d_zero got=%b want=%b", v[27:24], bus.zero, (v[7:0] == 8'h00)); end
            if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL mul_op%0d_illegal got=%b want=0", v[27:24], bus.illegal_op); end
            $display("op=%0d a=%h b=%h -> alu_out=%h after %0d cycles", v[27:24], v[23:16], v[15:8], bus.alu_out, k + 1);
        end
    endtask

    task automatic test_back_to_back;
        int k;
        drive(4'd11, 8'h06, 8'h07);
        tick();
        drive(4'd1, 8'h03, 8'h04);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            tick();
            k++;
        end
        checks += 3;
        if (bus.alu_out !== 8'h2A) begin errors++; $display("FAIL b2b_mul_alu_out got=%h want=2a", bus.alu_out); end
        tick();
        bus.in_valid = 1'b0;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_add_out_valid got=%b want=1", bus.out_valid); end
        if (bus.alu_out !== 8'h07) begin errors++; $display("FAIL b2b_add_alu_out got=%h want=07", bus.alu_out); end
        $display("mul then held add -> alu_out=%h", bus.alu_out);
        tick();
    endtask

    task automatic test_hold_and_stream;
        logic [7:0] exp;
        bus.out_ready = 1'b0;
        drive(4'd1, 8'h10, 8'h20);
        tick();
        drive(4'd1, 8'h01, 8'h01);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid cycle=%0d got=%b want=1", c, bus.out_valid); end
            if (bus.alu_out !== 8'h30) begin errors++; $display("FAIL hold_alu_out cycle=%0d got=%h want=30", c, bus.alu_out); end
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cycle=%0d got=%b want=0", c, bus.in_ready); end
            $display("hold cycle %0d: alu_out=%h in_ready=%b", c, bus.alu_out, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL release_out_valid got=%b want=1", bus.out_valid); end
        if (bus.alu_out !== 8'h02) begin errors++; $display("FAIL release_alu_out got=%h want=02", bus.alu_out); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'(i * 3 + 16);
            drive(4'd1, 8'(i * 3), 8'h10);
            tick();
            checks += 2;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d_out_valid got=%b want=1", i, bus.out_valid); end
            if (bus.alu_out !== exp) begin errors++; $display("FAIL stream%0d_alu_out got=%h want=%h", i, bus.alu_out, exp); end
            $display("stream %0d: alu_out=%h", i, bus.alu_out);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_busy;
        logic seen;
        drive(4'd11, 8'h03, 8'h05);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstbusy_out_valid got=%b want=0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstbusy_in_ready got=%b want=1", bus.in_ready); end
        if (bus.alu_out !== 8'h00) begin errors++; $display("FAIL rstbusy_alu_out got=%h want=00", bus.alu_out); end
        if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL rstbusy_illegal got=%b want=0", bus.illegal_op); end
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rstbusy_ghost_result got=%b want=0", seen); end
        $display("reset mid-multiply: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    endtask

    initial begin
        test_reset();
        test_single_ops();
        test_illegal();
        test_multiply();
        test_back_to_back();
        test_hold_and_stream();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
